// File: rtl/pattern_sequencer.sv
// pattern_sequencer: turns two bouncy push-buttons and two slide switches into
// a stable 3-bit pattern code for the seven-segment pattern decoder.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   key_run_n   raw run/stop button, active-low, asynchronous, bouncy
//   key_step_n  raw single-step button, active-low, asynchronous, bouncy
//   sw_dir      0 = count up, 1 = count down (sampled at each advance)
//   sw_auto     1 = timed advance allowed while running, 0 = timer frozen
//   code        registered pattern code, always 0..LAST_CODE
//   running     registered, 1 while in RUN
//   step_pulse  one-cycle strobe, high in the cycle the new code first shows

// key_conditioner: 2-FF synchronizer, debounce and press detection for one
// active-low key.
//   clk, rst_n  clock and asynchronous active-low reset
//   key_n       raw active-low key
//   press       one-cycle pulse on an accepted 1->0 (press) transition
module key_conditioner #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int              CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;   // accepted (debounced) key level
    logic          armed;   // a released key has been seen since reset
    logic [CW-1:0] cnt;
    logic          flip;

    // The synchronizer resets to "pressed" so a key held through reset
    // release never looks like a fresh press: arming needs a real release.
    assign flip  = (sync[1] != level) && (cnt == CNT_LAST);
    assign press = flip && level && armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            level <= 1'b1;
            armed <= 1'b0;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], key_n};
            if (sync[1])
                armed <= 1'b1;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                level <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module pattern_sequencer #(
    parameter int TICK_DIV   = 25000000,
    parameter int DEB_CYCLES = 1000000,
    parameter int LAST_CODE  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_run_n,
    input  logic       key_step_n,
    input  logic       sw_dir,
    input  logic       sw_auto,
    output logic [2:0] code,
    output logic       running,
    output logic       step_pulse
);
    localparam int NUM_KEYS = 2;
    localparam int KEY_RUN  = 0;
    localparam int KEY_STEP = 1;

    localparam int            TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [2:0]    CODE_LAST = 3'(LAST_CODE);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [NUM_KEYS-1:0] key_raw_n;
    logic [NUM_KEYS-1:0] press;

    assign key_raw_n = {key_step_n, key_run_n};

    genvar k;
    generate
        for (k = 0; k < NUM_KEYS; k++) begin : g_key
            key_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_key (
                .clk   (clk),
                .rst_n (rst_n),
                .key_n (key_raw_n[k]),
                .press (press[k])
            );
        end
    endgenerate

    logic [0:0]    state;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          advance;
    logic [2:0]    next_code;

    assign tick = (state == RUN) && sw_auto && (tick_cnt == TICK_LAST);

    // A run press pre-empts everything in its cycle: a coincident tick is
    // dropped and an IDLE step press is ignored.
    assign advance = !press[KEY_RUN] &&
                     (((state == IDLE) && press[KEY_STEP]) || tick);

    assign running = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
        end else if (press[KEY_RUN]) begin
            // Clearing here makes the first advance land exactly TICK_DIV
            // cycles after the run press is accepted.
            state    <= (state == IDLE) ? RUN : IDLE;
            tick_cnt <= '0;
        end else if ((state == RUN) && sw_auto) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    always_comb begin
        next_code = code;
        if (sw_dir)
            next_code = (code == 3'd0) ? CODE_LAST : code - 3'd1;
        else
            next_code = (code >= CODE_LAST) ? 3'd0 : code + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code       <= 3'd0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= advance;
            if (advance)
                code <= next_code;
        end
    end
endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Upstream driver for the lab's 3-bit pattern decoder that feeds the dual seven-segment display.
- Turns two raw push-buttons and two slide switches into a stable 3-bit pattern code.
- The code either auto-advances on a divided timebase or single-steps, through codes 0..LAST_CODE, up or down.
- Codes above LAST_CODE, 6 and 7 included, are never produced; the downstream decoder's default pattern is reserved for board-level faults.

Parameters:
TICK_DIV, 25000000, clk cycles per auto-advance step (0.5 s at 50 MHz); must be >= 2
DEB_CYCLES, 1000000, cycles a synchronized key level must be stable before it is accepted (20 ms at 50 MHz); must be >= 1
LAST_CODE, 5, highest code emitted; wrap point; 1..7

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
key_run_n  input  1  raw run/stop push-button, active-low, asynchronous to clk, bouncy
key_step_n  input  1  raw single-step push-button, active-low, asynchronous, bouncy
sw_dir  input  1  0 = count up, 1 = count down; sampled at each advance
sw_auto  input  1  1 = timed advance allowed while running; 0 = timer frozen
code  output  3  pattern code to downstream decoder, registered
running  output  1  1 while in RUN state, registered
step_pulse  output  1  one-cycle strobe, high in the cycle after code changes

Behaviour:
- Reset (rst_n low, async) values: code=0, running=0, step_pulse=0, tick counter=0, debounce counters=0. Debounced key levels reset to 1 (released).
- Clock and reset: single clock domain; reset asserts asynchronously and releases on the clock.
- Key path, per key:
  - 2-FF synchronizer.
  - Debounce counter: counts while the synchronized level differs from the accepted level, clears when they match; on reaching DEB_CYCLES the accepted level flips.
  - Press event: one-cycle pulse on an accepted 1->0 transition. Release produces nothing.
  - Latency: raw stable press to press pulse = 2 sync + DEB_CYCLES cycles (+-1).
- FSM states:
  - IDLE: running=0. run press -> RUN. step press -> one advance, stay IDLE.
  - RUN: running=1. run press -> IDLE. step press is ignored. tick -> one advance.
- Tick:
  - Tick counter runs only in RUN with sw_auto=1.
  - It counts 0..TICK_DIV-1; tick is asserted when the count is TICK_DIV-1, and the counter then returns to 0.
  - Counter clears on every IDLE->RUN transition, so the first advance is exactly TICK_DIV cycles after the run press is accepted.
  - sw_auto=0 in RUN holds the counter value (pause); it resumes from there.
- Advance:
  - Up: code = (code==LAST_CODE) ? 0 : code+1.
  - Down: code = (code==0) ? LAST_CODE : code-1.
  - step_pulse=1 in the following cycle.
- Simultaneous events:
  - Run press and tick in the same cycle: the stop takes effect and the tick is dropped.
  - Run and step presses in the same cycle in IDLE: run wins, no advance.
  - At most one advance per cycle.
- A sw_dir change affects only the next advance; no glitch on code.
- Reset mid-RUN or mid-debounce: everything returns to reset values immediately. A key held through reset release is not reported as a press until it is released and pressed again.
- Invariant: code <= LAST_CODE at all times.

Test Plan (TICK_DIV=4, DEB_CYCLES=3, LAST_CODE=5):
- Reset, then a key_step_n press with 2-cycle bounce before a stable low -> exactly one advance, code 0->1, step_pulse high 1 cycle; no second advance on release.
- Run press, sw_auto=1, sw_dir=0 -> running=1; code goes 1,2,3,4,5,0,1 with advances exactly 4 cycles apart, the first 4 cycles after press acceptance.
- In RUN at code=2, sw_dir=1 -> sequence 1,0,5,4. Step presses during RUN -> no extra advance.
- In RUN, sw_auto=0 for 10 cycles then 1 -> no advance during the pause; the next advance comes after the remaining tick count.
- Run press aligned with a tick cycle -> running=0, code unchanged. IDLE step at code=0 with sw_dir=1 -> code=5.
- Assert rst_n low mid-RUN with code=3 and key_run_n held low through release -> code=0, running=0 immediately, and no RUN entry until the key is released and pressed again.
